uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised successor to the single-word UART: full-duplex serial transceiver with a configurable frame format and TX/RX FIFOs.
- Frame format covers data width, oversample ratio, parity mode and stop-bit count.
- Sits between a host word interface (valid/ready-style push/pop) and the rx/tx pins.
- Two instances cross-wired tx→rx form the standard bring-up loopback.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
- CLKS_PER_BIT, 4, clk cycles per serial bit (≥4, even).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 4, entries in each of TX and RX FIFOs (power of 2, ≥2).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  DATA_BITS  word to transmit.
- wr_en  in  1  push din into TX FIFO when wr_rdy=1.
- wr_rdy  out  1  TX FIFO not full.
- dout  out  DATA_BITS  head of RX FIFO (first-word fall-through).
- rd_en  in  1  pop RX FIFO head when rd_rdy=1.
- rd_rdy  out  1  RX FIFO not empty.
- frame_err  out  1  flag stored with head word: its stop bit(s) sampled low.
- parity_err  out  1  flag stored with head word: parity mismatch (0 when PARITY=0).
- overrun  out  1  sticky: a received word was dropped because the RX FIFO was full.
- ovr_clr  in  1  clears overrun (ovr_clr wins over a same-cycle set).
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.

Behaviour:
- Reset (async assert, sync-to-clk effect on release):
  - tx=1, wr_rdy=1, rd_rdy=0, dout=0, frame_err=0, parity_err=0, overrun=0.
  - Both FIFOs emptied; both FSMs to IDLE; rx synchroniser preset to 1.
- Reset mid-frame aborts the frame; no partial word is pushed; tx returns high immediately.
- TX FIFO:
  - Push on wr_en&&wr_rdy; wr_en while full is ignored, with no corruption.
  - Simultaneous push and FSM pop while full is not allowed: wr_rdy=0 blocks the push that cycle.
- TX FSM (IDLE→START→DATA→PARITY→STOP→IDLE):
  - Word pushed in cycle N into an empty FIFO with the FSM in IDLE: tx falls at the clk edge ending cycle N+1.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - PARITY state is skipped when PARITY=0.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
  - Back-to-back words have no idle gap: the next START follows the last stop cycle directly.
- Parity bit: even = XOR of data bits; odd = its inverse.
- RX path:
  - rx passes through a 2-FF synchroniser (2-cycle latency).
  - States: IDLE→START→DATA→PARITY→STOP→IDLE.
  - IDLE: synchronised falling edge starts a counter; sample at CLKS_PER_BIT/2.
  - Start sampled high → glitch; return to IDLE, nothing pushed.
  - Subsequent bits sampled every CLKS_PER_BIT at mid-bit.
  - Only the first stop bit is checked; frame_err = first stop sample==0.
  - On a frame_err frame, RX waits for rx high before re-arming (no false start on a break).
- RX FIFO:
  - Word plus {frame_err, parity_err} is pushed one cycle after the stop sample.
  - If the FIFO is full, the word is dropped, overrun=1, and contents are unchanged.
  - rd_rdy rises the cycle after the push.
  - rd_en pops; dout/flags show the next entry the following cycle.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare and wrap correctly.

Test Plan:
- Defaults; two instances cross-wired; u1 writes 0xE8 → u2 rd_rdy within 40+4 cycles, dout=0xE8, both err flags 0.
- Full duplex: u1 sends 0xCA and u2 sends 0x4B in the same cycle → u2 dout=0xCA, u1 dout=0x4B, no errors.
- PARITY=2, DATA_BITS=7: bench drives 0x55 with the parity bit inverted → rd_rdy=1, dout=0x55, parity_err=1; a correct frame then gives parity_err=0.
- Stop bit forced low on 0x3C → dout=0x3C, frame_err=1; RX ignores further edges until rx high, then the next 0x81 is received clean.
- FIFO_DEPTH=4: send 5 words 0x01..0x05 with no reads:
  - After 4 pushes, wr_rdy=0 on TX side when 5 are written back-to-back.
  - RX holds 0x01..0x04, overrun=1, 0x05 lost.
  - ovr_clr → overrun=0.
  - 4 pops return 0x01..0x04 then rd_rdy=0.
- Reset and glitch: assert rst mid-data-bit of 0xA5 → tx=1 immediately, no RX push. A 1-cycle low pulse on rx → no push; TX wrap test pushes 12 words through depth 4 → all received in order.

Source files
------------

// File: rtl/uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_core_param
// Purpose  : Full-duplex UART with configurable frame format and TX/RX FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 wr_rdy,
  output logic [DATA_BITS-1:0] dout,
  input  logic                 rd_en,
  output logic                 rd_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr,
  input  logic                 rx,
  output logic                 tx
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam int c_bw = $clog2(DATA_BITS);
  localparam int c_rw = DATA_BITS + 2;
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_stop_last = c_cw'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_half      = c_cw'(CLKS_PER_BIT / 2);
  localparam logic [c_cw-1:0] c_full      = c_cw'(CLKS_PER_BIT);
  localparam logic [c_bw-1:0] c_dlast     = c_bw'(DATA_BITS - 1);
  localparam logic            c_odd       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [c_aw:0]        r_tx_wp;
  logic [c_aw:0]        r_tx_rp;
  logic                 w_tx_empty;
  logic                 w_tx_full;
  logic                 w_tx_push;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[c_aw] != r_tx_rp[c_aw]) &&
                      (r_tx_wp[c_aw-1:0] == r_tx_rp[c_aw-1:0]);
  assign w_tx_push  = wr_en && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rp[c_aw-1:0]];
  assign wr_rdy     = !w_tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_tx_wp <= '0;
    else if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[c_aw-1:0]] <= din;
  end

  // ---------------------------------------------------------------- TX FSM
  state_t               r_tx_st;
  logic [c_cw-1:0]      r_tx_cnt;
  logic [c_bw-1:0]      r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh;
  logic                 r_tx_par;
  logic                 r_tx;
  logic                 w_tx_start;

  // A new frame can start from IDLE or straight out of the last stop cycle.
  assign w_tx_start = !w_tx_empty &&
                      ((r_tx_st == S_IDLE) ||
                       (r_tx_st == S_STOP && r_tx_cnt == c_stop_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_tx     <= 1'b1;
      r_tx_rp  <= '0;
    end else if (w_tx_start) begin
      r_tx_sh  <= w_tx_head;
      r_tx_par <= (^w_tx_head) ^ c_odd;
      r_tx_rp  <= r_tx_rp + 1'b1;
      r_tx_cnt <= '0;
      r_tx     <= 1'b0;
      r_tx_st  <= S_START;
    end else begin
      case (r_tx_st)
        S_IDLE: r_tx <= 1'b1;
        S_START: begin
          if (r_tx_cnt == c_bit_last) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx     <= r_tx_sh[0];
            r_tx_st  <= S_DATA;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_tx_cnt == c_bit_last) begin
            r_tx_cnt <= '0;
            r_tx_sh  <= r_tx_sh >> 1;
            if (r_tx_bit == c_dlast) begin
              if (PARITY != 0) begin
                r_tx    <= r_tx_par;
                r_tx_st <= S_PAR;
              end else begin
                r_tx    <= 1'b1;
                r_tx_st <= S_STOP;
              end
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_tx     <= r_tx_sh[1];
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_PAR: begin
          if (r_tx_cnt == c_bit_last) begin
            r_tx_cnt <= '0;
            r_tx     <= 1'b1;
            r_tx_st  <= S_STOP;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_tx_cnt == c_stop_last) begin
            r_tx    <= 1'b1;
            r_tx_st <= S_IDLE;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: begin
          r_tx    <= 1'b1;
          r_tx_st <= S_IDLE;
        end
      endcase
    end
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------- RX sync
  logic r_rx_s1, r_rx_s2, r_rx_d;
  logic w_rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_d & ~r_rx_s2;

  // ---------------------------------------------------------------- RX FSM
  state_t               r_rx_st;
  logic [c_cw-1:0]      r_rx_cnt;
  logic [c_bw-1:0]      r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_sh;
  logic                 r_rx_ferr;
  logic                 r_rx_perr;
  logic                 r_rx_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st   <= S_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_ferr <= 1'b0;
      r_rx_perr <= 1'b0;
      r_rx_push <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_st)
        S_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt  <= c_cw'(1);
            r_rx_perr <= 1'b0;
            r_rx_st   <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == c_half) begin
            r_rx_cnt <= c_cw'(1);
            r_rx_bit <= '0;
            r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (r_rx_cnt == c_full) begin
            r_rx_cnt <= c_cw'(1);
            r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_bit == c_dlast) r_rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
            else                     r_rx_bit <= r_rx_bit + 1'b1;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_PAR: begin
          if (r_rx_cnt == c_full) begin
            r_rx_cnt  <= c_cw'(1);
            r_rx_perr <= r_rx_s2 ^ (^r_rx_sh) ^ c_odd;
            r_rx_st   <= S_STOP;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_rx_cnt == c_full) begin
            r_rx_ferr <= ~r_rx_s2;
            r_rx_push <= 1'b1;
            // A low stop bit may be a line break: wait for idle before re-arming.
            r_rx_st   <= r_rx_s2 ? S_IDLE : S_BRK;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        S_BRK: if (r_rx_s2) r_rx_st <= S_IDLE;
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [c_rw-1:0] r_rx_mem [FIFO_DEPTH];
  logic [c_aw:0]   r_rx_wp;
  logic [c_aw:0]   r_rx_rp;
  logic            r_ovr;
  logic            w_rx_empty;
  logic            w_rx_full;
  logic            w_rx_wr;
  logic            w_rx_rd;
  logic [c_rw-1:0] w_rx_head;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[c_aw] != r_rx_rp[c_aw]) &&
                      (r_rx_wp[c_aw-1:0] == r_rx_rp[c_aw-1:0]);
  assign w_rx_wr    = r_rx_push && !w_rx_full;
  assign w_rx_rd    = rd_en && !w_rx_empty;
  assign w_rx_head  = r_rx_mem[r_rx_rp[c_aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_rx_wr) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_rd) r_rx_rp <= r_rx_rp + 1'b1;
      if (ovr_clr)                       r_ovr <= 1'b0;
      else if (r_rx_push && w_rx_full)   r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wp[c_aw-1:0]] <= {r_rx_ferr, r_rx_perr, r_rx_sh};
  end

  // Memory is not reset, so the head is masked to zero while empty.
  assign {frame_err, parity_err, dout} = w_rx_empty ? '0 : w_rx_head;
  assign rd_rdy  = !w_rx_empty;
  assign overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_core_param
// Purpose  : Scoreboard bench: loopback pair plus two bench-driven receivers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] din1, din2, dout1, dout2, din4, dout4;
  logic [6:0] din3, dout3;
  logic wr_en1, wr_en2, wr_en3, wr_en4, wr_rdy1, wr_rdy2, wr_rdy3, wr_rdy4;
  logic rd_en1, rd_en2, rd_en3, rd_en4, rd_rdy1, rd_rdy2, rd_rdy3, rd_rdy4;
  logic fe1, fe2, fe3, fe4, pe1, pe2, pe3, pe4, ov1, ov2, ov3, ov4;
  logic oc1, oc2, oc3, oc4, tx1, tx2, tx3, tx4, rx3, rx4;

  uart_core_param u1 (.clk(clk), .rst(rst), .din(din1), .wr_en(wr_en1), .wr_rdy(wr_rdy1),
    .dout(dout1), .rd_en(rd_en1), .rd_rdy(rd_rdy1), .frame_err(fe1), .parity_err(pe1),
    .overrun(ov1), .ovr_clr(oc1), .rx(tx2), .tx(tx1));
  uart_core_param u2 (.clk(clk), .rst(rst), .din(din2), .wr_en(wr_en2), .wr_rdy(wr_rdy2),
    .dout(dout2), .rd_en(rd_en2), .rd_rdy(rd_rdy2), .frame_err(fe2), .parity_err(pe2),
    .overrun(ov2), .ovr_clr(oc2), .rx(tx1), .tx(tx2));
  uart_core_param #(.DATA_BITS(7), .PARITY(2)) u3 (.clk(clk), .rst(rst), .din(din3),
    .wr_en(wr_en3), .wr_rdy(wr_rdy3), .dout(dout3), .rd_en(rd_en3), .rd_rdy(rd_rdy3),
    .frame_err(fe3), .parity_err(pe3), .overrun(ov3), .ovr_clr(oc3), .rx(rx3), .tx(tx3));
  uart_core_param u4 (.clk(clk), .rst(rst), .din(din4), .wr_en(wr_en4), .wr_rdy(wr_rdy4),
    .dout(dout4), .rd_en(rd_en4), .rd_rdy(rd_rdy4), .frame_err(fe4), .parity_err(pe4),
    .overrun(ov4), .ovr_clr(oc4), .rx(rx4), .tx(tx4));

  typedef struct packed { logic [8:0] d; logic fe; logic pe; } exp_t;
  exp_t q1[$], q2[$], q3[$], q4[$];
  bit   mon1 = 1'b1, mon2 = 1'b1, mon3 = 1'b1, mon4 = 1'b1;
  int   n_tests = 0, n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(string name, logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s unexpected word: got %0h expected none", name, act);
  endfunction

  // Monitors: pop the head whenever the DUT presents one and compare it.
  initial begin
    exp_t e;
    rd_en1 = 1'b0;
    forever begin
      @(negedge clk);
      rd_en1 = 1'b0;
      if (mon1 && rd_rdy1) begin
        if (q1.size() == 0) unexpected("u1", {dout1, fe1, pe1});
        else begin e = q1.pop_front(); chk("u1 rx word", {1'b0, dout1, fe1, pe1}, e); end
        rd_en1 = 1'b1;
      end
    end
  end
  initial begin
    exp_t e;
    rd_en2 = 1'b0;
    forever begin
      @(negedge clk);
      rd_en2 = 1'b0;
      if (mon2 && rd_rdy2) begin
        if (q2.size() == 0) unexpected("u2", {dout2, fe2, pe2});
        else begin e = q2.pop_front(); chk("u2 rx word", {1'b0, dout2, fe2, pe2}, e); end
        rd_en2 = 1'b1;
      end
    end
  end
  initial begin
    exp_t e;
    rd_en3 = 1'b0;
    forever begin
      @(negedge clk);
      rd_en3 = 1'b0;
      if (mon3 && rd_rdy3) begin
        if (q3.size() == 0) unexpected("u3", {dout3, fe3, pe3});
        else begin e = q3.pop_front(); chk("u3 rx word", {2'b00, dout3, fe3, pe3}, e); end
        rd_en3 = 1'b1;
      end
    end
  end
  initial begin
    exp_t e;
    rd_en4 = 1'b0;
    forever begin
      @(negedge clk);
      rd_en4 = 1'b0;
      if (mon4 && rd_rdy4) begin
        if (q4.size() == 0) unexpected("u4", {dout4, fe4, pe4});
        else begin e = q4.pop_front(); chk("u4 rx word", {1'b0, dout4, fe4, pe4}, e); end
        rd_en4 = 1'b1;
      end
    end
  end

  task automatic wr1(input logic [7:0] d, input bit expect_rx);
    int t = 0;
    @(negedge clk);
    while (!wr_rdy1 && t < 500) begin @(negedge clk); t++; end
    if (!wr_rdy1) begin
      n_tests++; n_fail++;
      $display("FAIL u1 wr_rdy timeout: got 0 expected 1");
    end else begin
      din1 = d; wr_en1 = 1'b1;
      if (expect_rx) q2.push_back({1'b0, d, 2'b00});
      @(posedge clk); #1 wr_en1 = 1'b0;
    end
  endtask

  task automatic wr2(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!wr_rdy2 && t < 500) begin @(negedge clk); t++; end
    if (!wr_rdy2) begin
      n_tests++; n_fail++;
      $display("FAIL u2 wr_rdy timeout: got 0 expected 1");
    end else begin
      din2 = d; wr_en2 = 1'b1;
      q1.push_back({1'b0, d, 2'b00});
      @(posedge clk); #1 wr_en2 = 1'b0;
    end
  endtask

  task automatic bit_time(input int which, input logic v);
    if (which == 3) rx3 = v; else rx4 = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives a frame on rx3 (7 data bits, odd parity) or rx4 (8 bits, no parity).
  task automatic bang(input int which, input logic [8:0] d, input bit flip, input bit stop_low);
    int   nb    = (which == 3) ? 7 : 8;
    bit   par   = (which == 3);
    int   ones  = 0;
    logic pbit;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    pbit = ((ones % 2) == 0) ^ flip;
    if (which == 3) q3.push_back({d, stop_low, flip});
    else            q4.push_back({d, stop_low, 1'b0});
    @(negedge clk);
    bit_time(which, 1'b0);
    for (int i = 0; i < nb; i++) bit_time(which, d[i]);
    if (par) bit_time(which, pbit);
    bit_time(which, !stop_low);
    if (stop_low) repeat (5) bit_time(which, 1'b0);
    bit_time(which, 1'b1);
  endtask

  task automatic drain(input int budget, input string name);
    int t = 0;
    while ((q1.size() + q2.size() + q3.size() + q4.size()) != 0 && t < budget) begin
      @(negedge clk); t++;
    end
    chk(name, q1.size() + q2.size() + q3.size() + q4.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    din1 = '0; din2 = '0; din3 = '0; din4 = '0;
    wr_en1 = 0; wr_en2 = 0; wr_en3 = 0; wr_en4 = 0;
    oc1 = 0; oc2 = 0; oc3 = 0; oc4 = 0;
    rx3 = 1'b1; rx4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", tx1, 1);
    chk("reset wr_rdy", wr_rdy1, 1);
    chk("reset rd_rdy", rd_rdy2, 0);
    chk("reset dout", dout2, 0);
    chk("reset flags", {fe2, pe2, ov2}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback 0xE8 with start-edge and delivery timing.
    din1 = 8'hE8; wr_en1 = 1'b1; q2.push_back({9'h0E8, 2'b00});
    @(posedge clk); #1 wr_en1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) chk("tx high before start", tx1, 1);
      if (i == 2) chk("tx start edge", tx1, 0);
      if (rd_rdy2) begin lat = i; break; end
    end
    chk("loopback within 44 cycles", (lat > 0 && lat <= 44), 1);
    drain(60, "loopback drain");

    // Full duplex in the same cycle.
    fork
      wr1(8'hCA, 1'b1);
      wr2(8'h4B);
    join
    drain(120, "duplex drain");

    // Odd parity: inverted parity bit, then a correct frame.
    bang(3, 9'h055, 1'b1, 1'b0);
    bang(3, 9'h055, 1'b0, 1'b0);
    drain(40, "parity drain");

    // Stop bit forced low followed by a break, then a clean frame.
    bang(4, 9'h03C, 1'b0, 1'b1);
    bang(4, 9'h081, 1'b0, 1'b0);
    drain(40, "framing drain");

    // Single-cycle glitch on rx.
    @(negedge clk); rx4 = 1'b0;
    @(negedge clk); rx4 = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch no push", rd_rdy4, 0);

    // Overrun: five words with no reads; the receiver keeps only FIFO_DEPTH.
    mon2 = 1'b0;
    for (int i = 1; i <= 5; i++) wr1(8'(i), i <= 4);
    @(negedge clk);
    chk("tx fifo full after burst", wr_rdy1, 0);
    din1 = 8'h06; wr_en1 = 1'b1;
    @(posedge clk); #1 wr_en1 = 1'b0;
    repeat (280) @(negedge clk);
    chk("overrun set", ov2, 1);
    chk("rx head after overrun", {rd_rdy2, dout2}, 9'h101);
    oc2 = 1'b1;
    @(posedge clk); #1 oc2 = 1'b0;
    @(negedge clk);
    chk("overrun cleared", ov2, 0);
    mon2 = 1'b1;
    drain(60, "overrun drain");
    repeat (2) @(negedge clk);
    chk("rx empty after pops", rd_rdy2, 0);

    // Reset in the middle of data bit 1 of 0xA5 (bit value 0).
    @(negedge clk); din1 = 8'hA5; wr_en1 = 1'b1;
    @(posedge clk); #1 wr_en1 = 1'b0;
    repeat (11) @(negedge clk);
    chk("tx mid-frame bit", tx1, 0);
    rst = 1'b1;
    #1 chk("tx high on reset", tx1, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no partial push", rd_rdy2, 0);

    // Random traffic on all paths; twelve words wrap the depth-4 FIFOs.
    fork
      for (int i = 0; i < 12; i++) wr1(8'($urandom), 1'b1);
      for (int i = 0; i < 12; i++) wr2(8'($urandom));
      for (int i = 0; i < 10; i++)
        bang(3, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      for (int i = 0; i < 10; i++)
        bang(4, 9'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 3) == 0);
    join
    drain(400, "random drain");
    chk("no overrun after random", {ov1, ov2, ov3, ov4}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
